// File: rtl/pio_read_completer_if.sv
// rtl/pio_read_completer_if.sv - PIO read request, register port and completion signal bundle
// PIO_READ_STATS_EN adds the statistics counters to the bundle.
interface pio_read_completer_if;
    logic        rx_read_valid;
    logic [23:0] rx_read_rid_tag;
    logic [12:0] rx_read_address;
    logic        rx_read_ready;

    logic        reg_read_en;
    logic [12:0] reg_read_address;
    logic [63:0] reg_read_data;

    logic        read_completion_valid;
    logic [23:0] read_completion_rid_tag;
    logic [3:0]  read_completion_lower_addr;
    logic [63:0] read_completion_data;
    logic        read_completion_ready;

    logic        overflow;

`ifdef PIO_READ_STATS_EN
    logic [15:0] stat_completions;
    logic [7:0]  stat_drops;

    modport master (
        output rx_read_valid, rx_read_rid_tag, rx_read_address,
        input  rx_read_ready,
        input  reg_read_en, reg_read_address,
        output reg_read_data,
        input  read_completion_valid, read_completion_rid_tag,
        input  read_completion_lower_addr, read_completion_data,
        output read_completion_ready,
        input  overflow,
        input  stat_completions, stat_drops
    );

    modport slave (
        input  rx_read_valid, rx_read_rid_tag, rx_read_address,
        output rx_read_ready,
        output reg_read_en, reg_read_address,
        input  reg_read_data,
        output read_completion_valid, read_completion_rid_tag,
        output read_completion_lower_addr, read_completion_data,
        input  read_completion_ready,
        output overflow,
        output stat_completions, stat_drops
    );
`else
    modport master (
        output rx_read_valid, rx_read_rid_tag, rx_read_address,
        input  rx_read_ready,
        input  reg_read_en, reg_read_address,
        output reg_read_data,
        input  read_completion_valid, read_completion_rid_tag,
        input  read_completion_lower_addr, read_completion_data,
        output read_completion_ready,
        input  overflow
    );

    modport slave (
        input  rx_read_valid, rx_read_rid_tag, rx_read_address,
        output rx_read_ready,
        output reg_read_en, reg_read_address,
        input  reg_read_data,
        output read_completion_valid, read_completion_rid_tag,
        output read_completion_lower_addr, read_completion_data,
        input  read_completion_ready,
        output overflow
    );
`endif
endinterface

// File: rtl/pio_read_completer.sv
// rtl/pio_read_completer.sv - queues PIO read requests, fetches registers, presents one completion at a time
// PIO_READ_STATS_EN adds completion/drop statistics counters.
module pio_read_completer #(
    parameter int QUEUE_DEPTH = 4,
    parameter int REG_LATENCY = 2
) (
    input logic                 clock,
    input logic                 reset_n,
    pio_read_completer_if.slave bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = 2;
    localparam logic [CW-1:0] LAT_INIT = CW'(REG_LATENCY - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    logic [23:0] q_rid_tag [QUEUE_DEPTH];
    logic [12:0] q_address [QUEUE_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ready_q, ready_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reg_en_q, reg_en_d;
    logic [12:0]   reg_addr_q, reg_addr_d;
    logic          cpl_valid_q, cpl_valid_d;
    logic [23:0]   cpl_rid_tag_q, cpl_rid_tag_d;
    logic [3:0]    cpl_lower_q, cpl_lower_d;
    logic [63:0]   cpl_data_q, cpl_data_d;

    logic          full, empty, full_d;
    logic          push, drop, pop;
    logic [23:0]   head_rid_tag;
    logic [12:0]   head_address;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Admission looks only at the current fill level, so a same-cycle pop never frees a full queue.
    assign push = bus.rx_read_valid && !full;
    assign drop = bus.rx_read_valid && full;
    assign pop  = (state_q == ST_PRESENT) && bus.read_completion_ready;

    assign head_rid_tag = q_rid_tag[rd_ptr_q[AW-1:0]];
    assign head_address = q_address[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            q_rid_tag[wr_ptr_q[AW-1:0]] <= bus.rx_read_rid_tag;
            q_address[wr_ptr_q[AW-1:0]] <= bus.rx_read_address;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, pop};
        full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        ready_d    = !full_d;
        overflow_d = overflow_q | drop;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reg_en_d      = 1'b0;
        reg_addr_d    = reg_addr_q;
        cpl_valid_d   = cpl_valid_q;
        cpl_rid_tag_d = cpl_rid_tag_q;
        cpl_lower_d   = cpl_lower_q;
        cpl_data_d    = cpl_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    reg_en_d   = 1'b1;
                    reg_addr_d = head_address;
                    cnt_d      = LAT_INIT;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The head entry is still in the queue here; it is only popped on consume.
                if (cnt_q == '0) begin
                    cpl_data_d    = bus.reg_read_data;
                    cpl_rid_tag_d = head_rid_tag;
                    cpl_lower_d   = head_address[3:0];
                    cpl_valid_d   = 1'b1;
                    state_d       = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PRESENT: begin
                if (bus.read_completion_ready) begin
                    cpl_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cpl_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ready_q       <= 1'b0;
            overflow_q    <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            reg_en_q      <= 1'b0;
            reg_addr_q    <= '0;
            cpl_valid_q   <= 1'b0;
            cpl_rid_tag_q <= '0;
            cpl_lower_q   <= '0;
            cpl_data_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ready_q       <= ready_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reg_en_q      <= reg_en_d;
            reg_addr_q    <= reg_addr_d;
            cpl_valid_q   <= cpl_valid_d;
            cpl_rid_tag_q <= cpl_rid_tag_d;
            cpl_lower_q   <= cpl_lower_d;
            cpl_data_q    <= cpl_data_d;
        end
    end

    assign bus.rx_read_ready              = ready_q;
    assign bus.reg_read_en                = reg_en_q;
    assign bus.reg_read_address           = reg_addr_q;
    assign bus.read_completion_valid      = cpl_valid_q;
    assign bus.read_completion_rid_tag    = cpl_rid_tag_q;
    assign bus.read_completion_lower_addr = cpl_lower_q;
    assign bus.read_completion_data       = cpl_data_q;
    assign bus.overflow                   = overflow_q;

`ifdef PIO_READ_STATS_EN
    logic [15:0] stat_cpl_q, stat_cpl_d;
    logic [7:0]  stat_drop_q, stat_drop_d;

    always_comb begin
        stat_cpl_d  = stat_cpl_q + {15'd0, pop};
        stat_drop_d = stat_drop_q;
        if (drop && stat_drop_q != 8'hFF) begin
            stat_drop_d = stat_drop_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_cpl_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_cpl_q  <= stat_cpl_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign bus.stat_completions = stat_cpl_q;
    assign bus.stat_drops       = stat_drop_q;
`endif
endmodule

// File: tb/tb_pio_read_completer.sv
// tb/tb_pio_read_completer.sv - scoreboard bench for pio_read_completer
// Define PIO_READ_STATS_EN to also exercise the statistics counters.
module tb_pio_read_completer;
    logic clock;
    logic reset_n;

    pio_read_completer_if bus();

    pio_read_completer #(.QUEUE_DEPTH(4), .REG_LATENCY(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [23:0] rid;
        logic [3:0]  lo;
        logic [63:0] data;
    } cpl_t;

    cpl_t        exp_q[$];
    int          checks;
    int          errors;
    int          cpl_count;
    int          en_count;
    logic [63:0] mem [16];
    logic [63:0] reg_data;
    logic        auto_en;
    logic        auto_rdy;
    logic        man_rdy;
    int          ready_delay;
    logic        consumed;
    logic        prev_valid;
    logic [63:0] hold_data;
    logic [27:0] hold_hdr;

    assign bus.reg_read_data         = reg_data;
    assign bus.read_completion_ready = auto_rdy | man_rdy;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register file model: data is valid at the second edge after the strobe edge.
    always @(posedge clock) begin
        if (bus.reg_read_en) begin
            reg_data <= mem[bus.reg_read_address[3:0]];
            en_count <= en_count + 1;
        end else begin
            reg_data <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    always @(posedge clock) consumed <= reset_n && bus.read_completion_valid && bus.read_completion_ready;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (consumed) check("valid_low_after_ready", bus.read_completion_valid, 64'd0);
            if (bus.read_completion_valid && !prev_valid) begin
                cpl_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got rid_tag %0h expected none", bus.read_completion_rid_tag);
                end else begin
                    cpl_t e;
                    e = exp_q.pop_front();
                    check("cpl_rid_tag", {40'd0, bus.read_completion_rid_tag}, {40'd0, e.rid});
                    check("cpl_lower_addr", {60'd0, bus.read_completion_lower_addr}, {60'd0, e.lo});
                    check("cpl_data", bus.read_completion_data, e.data);
                end
                hold_data = bus.read_completion_data;
                hold_hdr  = {bus.read_completion_rid_tag, bus.read_completion_lower_addr};
            end else if (bus.read_completion_valid) begin
                check("cpl_stable", {bus.read_completion_rid_tag, bus.read_completion_lower_addr, bus.read_completion_data},
                      {hold_hdr, hold_data});
            end
            prev_valid = bus.read_completion_valid;
        end
    end

    initial begin
        auto_rdy = 1'b0;
        forever begin
            @(negedge clock);
            if (auto_en && reset_n && bus.read_completion_valid && !auto_rdy) begin
                repeat (ready_delay - 1) @(negedge clock);
                auto_rdy = 1'b1;
                @(negedge clock);
                auto_rdy = 1'b0;
            end
        end
    end

    task automatic send(input logic [12:0] a, input logic [23:0] rid, input bit accept);
        bus.rx_read_valid   = 1'b1;
        bus.rx_read_address = a;
        bus.rx_read_rid_tag = rid;
        check("rx_read_ready", {63'd0, bus.rx_read_ready}, {63'd0, accept});
        if (accept) exp_q.push_back('{rid, a[3:0], mem[a[3:0]]});
        @(negedge clock);
        bus.rx_read_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.read_completion_valid) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.read_completion_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got valid 0 expected 1");
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e0;
        checks = 0; errors = 0; cpl_count = 0; en_count = 0;
        auto_en = 1'b0; man_rdy = 1'b0; ready_delay = 1;
        reset_n = 1'b0;
        bus.rx_read_valid = 1'b0; bus.rx_read_address = '0; bus.rx_read_rid_tag = '0;
        for (int i = 0; i < 16; i++) mem[i] = 64'hA5A5_0000_0000_0000 | (64'h0001_0001_0001 * i);
        mem[5] = 64'h1122_3344_5566_7788;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_valid", {63'd0, bus.read_completion_valid}, 64'd0);
        check("rst_reg_en", {63'd0, bus.reg_read_en}, 64'd0);
        check("rst_overflow", {63'd0, bus.overflow}, 64'd0);
        check("rst_rx_ready", {63'd0, bus.rx_read_ready}, 64'd0);
        check("rst_data", bus.read_completion_data, 64'd0);
        reset_n = 1'b1;
        #1 check("rx_ready_at_release", {63'd0, bus.rx_read_ready}, 64'd0);
        @(negedge clock);
        check("rx_ready_after_clock", {63'd0, bus.rx_read_ready}, 64'd1);

        // 1: single read, latency and fields
        auto_en = 1'b1; ready_delay = 3;
        e0 = en_count;
        send(13'h005, 24'h01002A, 1'b1);
        check("t1_en_at_push", {63'd0, bus.reg_read_en}, 64'd0);
        @(negedge clock);
        check("t1_en", {63'd0, bus.reg_read_en}, 64'd1);
        check("t1_en_addr", {51'd0, bus.reg_read_address}, 64'd5);
        @(negedge clock);
        check("t1_en_one_cycle", {63'd0, bus.reg_read_en}, 64'd0);
        check("t1_valid_early", {63'd0, bus.read_completion_valid}, 64'd0);
        @(negedge clock);
        check("t1_valid_latency", {63'd0, bus.read_completion_valid}, 64'd1);
        wait_drain();
        check("t1_en_count", 64'(en_count - e0), 64'd1);

        // 2: four back-to-back requests
        ready_delay = 1;
        for (int i = 0; i < 4; i++) send(13'(i), 24'h0200_00 + 24'(i), 1'b1);
        wait_drain();

        // 3: stalled consumer, fifth request dropped
        auto_en = 1'b0;
        for (int i = 0; i < 4; i++) send(13'(8 + i), 24'h0300_00 + 24'(i), 1'b1);
        send(13'h00C, 24'h0300_04, 1'b0);
        check("t3_overflow", {63'd0, bus.overflow}, 64'd1);
        repeat (5) @(negedge clock);
        check("t3_overflow_sticky", {63'd0, bus.overflow}, 64'd1);
        auto_en = 1'b1; ready_delay = 2;
        wait_drain();
        check("t3_overflow_after_drain", {63'd0, bus.overflow}, 64'd1);
        check("t3_rx_ready_after_drain", {63'd0, bus.rx_read_ready}, 64'd1);

        // 4: ready outside PRESENT is ignored
        auto_en = 1'b0;
        c0 = cpl_count; e0 = en_count;
        man_rdy = 1'b1; @(negedge clock); man_rdy = 1'b0;
        repeat (3) @(negedge clock);
        check("t4_idle_no_cpl", 64'(cpl_count - c0), 64'd0);
        check("t4_idle_no_en", 64'(en_count - e0), 64'd0);
        send(13'h007, 24'h0400_07, 1'b1);
        @(negedge clock);
        check("t4_en", {63'd0, bus.reg_read_en}, 64'd1);
        man_rdy = 1'b1;
        @(negedge clock);
        @(negedge clock);
        man_rdy = 1'b0;
        check("t4_valid_held", {63'd0, bus.read_completion_valid}, 64'd1);
        repeat (4) @(negedge clock);
        check("t4_still_valid", {63'd0, bus.read_completion_valid}, 64'd1);
        auto_en = 1'b1; ready_delay = 1;
        wait_drain();
        check("t4_one_cpl", 64'(cpl_count - c0), 64'd1);

        // 5: reset while presenting with two entries queued
        auto_en = 1'b0;
        send(13'h008, 24'h0500_08, 1'b1);
        send(13'h009, 24'h0500_09, 1'b1);
        send(13'h00A, 24'h0500_0A, 1'b1);
        wait_valid();
        #2 reset_n = 1'b0;
        #1 check("t5_valid_async_drop", {63'd0, bus.read_completion_valid}, 64'd0);
        exp_q.delete();
        c0 = cpl_count; e0 = en_count;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check("t5_overflow_cleared", {63'd0, bus.overflow}, 64'd0);
        repeat (10) @(negedge clock);
        check("t5_no_en", 64'(en_count - e0), 64'd0);
        check("t5_no_cpl", 64'(cpl_count - c0), 64'd0);
        auto_en = 1'b1;
        send(13'h00B, 24'h0500_0B, 1'b1);
        wait_drain();
        check("t5_new_cpl", 64'(cpl_count - c0), 64'd1);

`ifdef PIO_READ_STATS_EN
        // 6: statistics counters
        do_reset();
        check("t6_stat_cpl_reset", {48'd0, bus.stat_completions}, 64'd0);
        auto_en = 1'b1; ready_delay = 1;
        for (int i = 0; i < 3; i++) send(13'(i + 1), 24'h0600_00 + 24'(i), 1'b1);
        wait_drain();
        auto_en = 1'b0;
        for (int i = 0; i < 4; i++) send(13'(i + 4), 24'h0601_00 + 24'(i), 1'b1);
        send(13'h00E, 24'h0602_00, 1'b0);
        send(13'h00F, 24'h0602_01, 1'b0);
        check("t6_stat_completions", {48'd0, bus.stat_completions}, 64'd3);
        check("t6_stat_drops", {56'd0, bus.stat_drops}, 64'd2);
        for (int i = 0; i < 298; i++) send(13'h00E, 24'h0603_00, 1'b0);
        check("t6_stat_drops_sat", {56'd0, bus.stat_drops}, 64'hFF);
        auto_en = 1'b1;
        wait_drain();
        check("t6_stat_completions_final", {48'd0, bus.stat_completions}, 64'd7);
`endif

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
